// File: rtl/sprite_dma_pkg.sv
// Shared types and default addresses for the sprite DMA engine.
// The state enum is reused by anything that needs to decode the FSM.
package sprite_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [15:0] DEF_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] DEF_DEST_ADDR    = 16'h2004;

endpackage

// File: rtl/sprite_dma.sv
// Sprite DMA: a CPU write to the trigger address halts the CPU and copies one page to DEST_ADDR.
// Build option SPRITE_DMA_ALIGN_EN inserts a one-cycle ALIGN state on odd parity.
module sprite_dma
  import sprite_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = DEF_TRIGGER_ADDR,
  parameter logic [15:0] DEST_ADDR    = DEF_DEST_ADDR,
  parameter int          LENGTH       = 256
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data_out,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] addr,
  output logic        rw,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in
);

`ifdef SPRITE_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [7:0] LAST = 8'(LENGTH - 1);

  state_t     state_q, state_d;
  logic       parity_q;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] latch_q, latch_d;
  logic       trig;

  assign trig = !cpu_rw && (cpu_addr == TRIGGER_ADDR);

  // State, counters and byte latch; parity free-runs from reset.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      latch_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      idx_q    <= idx_d;
      page_q   <= page_d;
      latch_q  <= latch_d;
    end
  end

  // Next-state logic and bus outputs decoded from registered state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    page_d     = page_q;
    latch_d    = latch_q;
    cpu_rdy    = 1'b0;
    dma_active = 1'b0;
    addr       = 16'h0000;
    rw         = 1'b1;
    data_out   = 8'h00;
    unique case (state_q)
      S_IDLE: begin
        cpu_rdy = 1'b1;
        if (trig) begin
          page_d  = cpu_data_out;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        idx_d   = 8'h00;
        state_d = (ALIGN_EN && parity_q) ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        dma_active = 1'b1;
        addr       = {page_q, 8'h00};
        state_d    = S_READ;
      end
      S_READ: begin
        dma_active = 1'b1;
        addr       = {page_q, idx_q};
        latch_d    = data_in;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        dma_active = 1'b1;
        rw         = 1'b0;
        addr       = DEST_ADDR;
        data_out   = latch_q;
        if (idx_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/sprite_dma.md
SPRITE_DMA -- requirements
Module: sprite_dma

Interface
REQ-001 SHALL have parameter TRIGGER_ADDR, default 16'h4014, the CPU write address that starts a transfer.
REQ-002 SHALL have parameter DEST_ADDR, default 16'h2004, the fixed write target for every copied byte.
REQ-003 SHALL have parameter LENGTH, default 256, the bytes per transfer (range 1..256).
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 nreset  in  1  reset, synchronous, active-low.
REQ-006 cpu_addr  in  16  CPU address, snooped.
REQ-007 cpu_rw  in  1  CPU direction, snooped (1 = read, 0 = write).
REQ-008 cpu_data_out  in  8  CPU write data, snooped; carries the source page.
REQ-009 cpu_rdy  out  1  0 = CPU halted.
REQ-010 dma_active  out  1  1 = this block owns the bus; system mux selects addr/rw/data_out from here.
REQ-011 addr  out  16  bus address driven by DMA.
REQ-012 rw  out  1  bus direction driven by DMA.
REQ-013 data_out  out  8  bus write data driven by DMA.
REQ-014 data_in  in  8  bus read data; valid by the rising edge ending a read cycle.

Function
REQ-015 SHALL implement the states IDLE, HALT, ALIGN, READ and WRITE.
REQ-016 Trigger: in IDLE with cpu_rw=0 and cpu_addr=TRIGGER_ADDR at a rising edge, SHALL latch page=cpu_data_out and enter HALT.
REQ-017 In HALT (exactly 1 cycle), cpu_rdy SHALL be 0, dma_active 0 and the byte index 0; next state SHALL be ALIGN if parity=1, else READ.
REQ-018 A parity bit SHALL toggle every cycle from reset, where it is 0.
REQ-019 ALIGN SHALL last 1 cycle with cpu_rdy=0, dma_active=1, rw=1 and addr held at {page,8'h00}, then go to READ.
REQ-020 READ SHALL drive addr={page,idx}, rw=1, dma_active=1, and capture data_in into a byte latch at the cycle end, then go to WRITE.
REQ-021 WRITE SHALL drive addr=DEST_ADDR, rw=0 and data_out=latch.
REQ-022 At the end of WRITE, if idx=LENGTH-1 the block SHALL go to IDLE, else idx+1 and go to READ.
REQ-023 idx SHALL be 8 bits and SHALL never wrap past LENGTH-1.
REQ-024 A transfer SHALL take 1+2*LENGTH cycles, plus 1 when aligned (513/514 at default).
REQ-025 cpu_rdy SHALL return to 1 in the first IDLE cycle after the final WRITE.
REQ-026 Triggers while not IDLE SHALL be ignored; the page SHALL not change mid-transfer.
REQ-027 A CPU write to any address other than TRIGGER_ADDR, and any CPU read of it, SHALL be ignored.
REQ-028 In IDLE, outputs SHALL be addr=0, rw=1, data_out=0, dma_active=0 and cpu_rdy=1.
REQ-029 All outputs SHALL be decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-030 With nreset=0 at a rising edge, the block SHALL enter IDLE with parity=0, idx=0, page=0 and latch=0, and drive the IDLE output values.
REQ-031 Reset mid-transfer SHALL abort immediately, with no further bus writes and cpu_rdy=1 the following cycle.

Configuration
REQ-032 With SPRITE_DMA_ALIGN_EN defined, ALIGN SHALL be inserted when parity=1 as in REQ-017.
REQ-033 Without SPRITE_DMA_ALIGN_EN, HALT SHALL always go to READ, ALIGN SHALL be unreachable, and every transfer SHALL take 1+2*LENGTH cycles.

Structure
REQ-034 Shared package sprite_dma_pkg SHALL hold the state enum and the constants for the default trigger and destination addresses.
REQ-035 The design SHALL be a single module with no sub-module; the parity bit, idx counter and FSM are small enough to stay inline.

Verification
REQ-036 Write 8'h02 to 16'h4014 at parity 0 -> 256 reads $0200..$02FF, each followed by a write to $2004 with the read byte; cpu_rdy low for exactly 513 cycles.
REQ-037 Same trigger at parity 1 with SPRITE_DMA_ALIGN_EN -> 514 low cycles, one ALIGN cycle before the first read; without the macro -> 513.
REQ-038 Memory $0300..$03FF = index XOR 8'hA5, trigger page 8'h03 -> the $2004 write sequence is 8'hA5,8'hA4,...,8'h5A.
REQ-039 Second write to $4014 (data 8'h07) during a transfer -> ignored; all reads stay in the original page.
REQ-040 nreset low at byte 100 -> next cycle cpu_rdy=1, dma_active=0, no further $2004 writes; a new trigger afterwards runs a full transfer.
REQ-041 LENGTH=1, trigger page 8'h00 -> exactly one read of $0000 and one write to $2004; cpu_rdy low for 3 cycles.
